decode_stage: RTL and testbench

RV32E instruction decode stage, between the fetch-to-decode skid buffer and the execute stage. Accepts one instruction word and its PC per handshake and classifies the instruction. Reads both source registers from the register file and produces a sign-extended immediate. Holds a one-entry output register toward execute, with register-busy tracking for RAW/WAW hazards and a flush path for control-flow redirects.

---
 rtl/rv32e_pkg.sv | 61 ++++++
 rtl/decode_stage_if.sv | 60 ++++++
 rtl/decode_scoreboard.sv | 51 +++++
 rtl/decode_stage.sv | 166 ++++++++++++++++
 tb/tb_decode_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32e_pkg.sv
`default_nettype none
// ============================================================================
// rv32e_pkg
// Shared RV32E decode types: op classes, immediate formats, major opcodes and
// the immediate generator used by the decode stage.
// Revision: 1.0 - initial release
// ============================================================================
package rv32e_pkg;

   typedef enum logic [3:0] {
      OP_LUI     = 4'd0,
      OP_AUIPC   = 4'd1,
      OP_JAL     = 4'd2,
      OP_JALR    = 4'd3,
      OP_BRANCH  = 4'd4,
      OP_LOAD    = 4'd5,
      OP_STORE   = 4'd6,
      OP_ALU_IMM = 4'd7,
      OP_ALU     = 4'd8,
      OP_SYSTEM  = 4'd9,
      OP_ILLEGAL = 4'd10
   } op_class_t;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_t;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
   localparam logic [6:0] OPC_ALU     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   // Builds the sign-extended immediate from the upper instruction bits;
   // the opcode bits never contribute to any immediate.
   function automatic logic [31:0] imm_gen(input imm_fmt_t fmt, input logic [31:7] inst);
      logic [31:0] imm;
      imm = 32'd0;
      case (fmt)
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'd0};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// decode_stage_if
// Bundles the fetch-side handshake, register-file read port, execute-side
// output register, writeback and flush signals of the decode stage.
// Revision: 1.0 - initial release
// ============================================================================
interface decode_stage_if
   import rv32e_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RW   = 4
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;

   logic [RW-1:0]   rf_rs1_addr;
   logic [RW-1:0]   rf_rs2_addr;
   logic [XLEN-1:0] rf_rs1_data;
   logic [XLEN-1:0] rf_rs2_data;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   op_class_t       out_op;
   logic [2:0]      out_funct3;
   logic            out_funct7b5;
   logic [RW-1:0]   out_rd;
   logic [XLEN-1:0] out_rs1_val;
   logic [XLEN-1:0] out_rs2_val;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   logic            wb_valid;
   logic [RW-1:0]   wb_rd;
   logic            flush;

   // Decode stage side
   modport slave (
      input  in_valid, in_inst, in_pc,
      input  rf_rs1_data, rf_rs2_data,
      input  out_ready, wb_valid, wb_rd, flush,
      output in_ready, rf_rs1_addr, rf_rs2_addr,
      output out_valid, out_pc, out_op, out_funct3, out_funct7b5, out_rd,
      output out_rs1_val, out_rs2_val, out_imm, out_illegal
   );

   // Surrounding pipeline side
   modport master (
      output in_valid, in_inst, in_pc,
      output rf_rs1_data, rf_rs2_data,
      output out_ready, wb_valid, wb_rd, flush,
      input  in_ready, rf_rs1_addr, rf_rs2_addr,
      input  out_valid, out_pc, out_op, out_funct3, out_funct7b5, out_rd,
      input  out_rs1_val, out_rs2_val, out_imm, out_illegal
   );
endinterface
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// decode_scoreboard
// Busy bit per architectural register: set when an instruction with a
// destination issues to execute, cleared when its writeback retires.
// Two combinational query ports serve the source-operand hazard checks.
// Revision: 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
   parameter int NREGS = 16,
   parameter int RW    = $clog2(NREGS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [RW-1:0]    issue_rd,
   input  logic             wb_valid,
   input  logic [RW-1:0]    wb_rd,
   input  logic             flush,
   input  logic [RW-1:0]    q1_addr,
   output logic             q1_busy,
   input  logic [RW-1:0]    q2_addr,
   output logic             q2_busy,
   output logic [NREGS-1:0] busy
);
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   // Next busy state: writeback clears first so a same-register issue wins
   always_comb begin
      w_busy_nxt = r_busy;
      if (wb_valid && (wb_rd != '0))
         w_busy_nxt[wb_rd] = 1'b0;
      if (issue_valid && !flush && (issue_rd != '0))
         w_busy_nxt[issue_rd] = 1'b1;
   end

   // Busy register, cleared by synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign q1_busy = (q1_addr != '0) && r_busy[q1_addr];
   assign q2_busy = (q2_addr != '0) && r_busy[q2_addr];
   assign busy    = r_busy;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage
// RV32E decode: classifies the instruction, reads both source operands,
// builds the immediate and holds one decoded entry toward execute, stalling
// on RAW/WAW hazards against the busy scoreboard and the held entry.
// Revision: 1.0 - initial release
// ============================================================================
module decode_stage
   import rv32e_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 16
) (
   input  logic          clock,
   input  logic          reset,
   decode_stage_if.slave bus
);
   logic [31:0]      w_inst;
   logic [3:0]       w_rs1;
   logic [3:0]       w_rs2;
   op_class_t        w_cls;
   imm_fmt_t         w_fmt;
   logic             w_known;
   logic             w_use1;
   logic             w_use2;
   logic             w_wrd;
   logic             w_illegal;
   op_class_t        w_op;
   logic [3:0]       w_rd;
   logic [31:0]      w_imm;
   logic             w_src1;
   logic             w_src2;
   logic             w_q1_busy;
   logic             w_q2_busy;
   logic [NREGS-1:0] w_busy;
   logic             w_hz;
   logic             w_in_ready;
   logic             w_xfer;
   logic             w_issue;

   logic             r_valid;
   logic [XLEN-1:0]  r_pc;
   op_class_t        r_op;
   logic [2:0]       r_funct3;
   logic             r_funct7b5;
   logic [3:0]       r_rd;
   logic [XLEN-1:0]  r_rs1_val;
   logic [XLEN-1:0]  r_rs2_val;
   logic [XLEN-1:0]  r_imm;
   logic             r_illegal;

   assign w_inst = bus.in_inst;
   assign w_rs1  = w_inst[18:15];
   assign w_rs2  = w_inst[23:20];

   assign bus.rf_rs1_addr = w_rs1;
   assign bus.rf_rs2_addr = w_rs2;

   // Opcode classification: op class, immediate format and register usage
   always_comb begin
      w_cls   = OP_ILLEGAL;
      w_fmt   = IMM_NONE;
      w_known = 1'b1;
      w_use1  = 1'b0;
      w_use2  = 1'b0;
      w_wrd   = 1'b0;
      case (w_inst[6:0])
         OPC_LUI:     begin w_cls = OP_LUI;     w_fmt = IMM_U; w_wrd = 1'b1; end
         OPC_AUIPC:   begin w_cls = OP_AUIPC;   w_fmt = IMM_U; w_wrd = 1'b1; end
         OPC_JAL:     begin w_cls = OP_JAL;     w_fmt = IMM_J; w_wrd = 1'b1; end
         OPC_JALR:    begin w_cls = OP_JALR;    w_fmt = IMM_I; w_wrd = 1'b1; w_use1 = 1'b1; end
         OPC_BRANCH:  begin w_cls = OP_BRANCH;  w_fmt = IMM_B; w_use1 = 1'b1; w_use2 = 1'b1; end
         OPC_LOAD:    begin w_cls = OP_LOAD;    w_fmt = IMM_I; w_wrd = 1'b1; w_use1 = 1'b1; end
         OPC_STORE:   begin w_cls = OP_STORE;   w_fmt = IMM_S; w_use1 = 1'b1; w_use2 = 1'b1; end
         OPC_ALU_IMM: begin w_cls = OP_ALU_IMM; w_fmt = IMM_I; w_wrd = 1'b1; w_use1 = 1'b1; end
         OPC_ALU:     begin w_cls = OP_ALU; w_wrd = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
         OPC_SYSTEM:  begin w_cls = OP_SYSTEM; end
         default:     begin w_known = 1'b0; end
      endcase
   end

   // x16-x31 do not exist in RV32E, so bit 4 of any used register field is illegal
   assign w_illegal = (w_inst[1:0] != 2'b11) || !w_known ||
                      (w_use1 && w_inst[19]) || (w_use2 && w_inst[24]) ||
                      (w_wrd && w_inst[11]);

   // Illegal instructions travel as a harmless bubble-like entry: no rd, no sources
   assign w_op   = w_illegal ? OP_ILLEGAL : w_cls;
   assign w_rd   = (w_wrd && !w_illegal) ? w_inst[10:7] : 4'd0;
   assign w_imm  = w_illegal ? 32'd0 : imm_gen(w_fmt, w_inst[31:7]);
   assign w_src1 = w_use1 && !w_illegal && (w_rs1 != 4'd0);
   assign w_src2 = w_use2 && !w_illegal && (w_rs2 != 4'd0);

   decode_scoreboard #(
      .NREGS (NREGS),
      .RW    (4)
   ) u_scoreboard (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (w_issue),
      .issue_rd    (r_rd),
      .wb_valid    (bus.wb_valid),
      .wb_rd       (bus.wb_rd),
      .flush       (bus.flush),
      .q1_addr     (w_rs1),
      .q1_busy     (w_q1_busy),
      .q2_addr     (w_rs2),
      .q2_busy     (w_q2_busy),
      .busy        (w_busy)
   );

   // The held entry has not set its busy bit yet, so it is checked directly
   assign w_hz = (w_src1 && (w_q1_busy || (r_valid && (r_rd == w_rs1)))) ||
                 (w_src2 && (w_q2_busy || (r_valid && (r_rd == w_rs2)))) ||
                 ((w_rd != 4'd0) && (w_busy[w_rd] || (r_valid && (r_rd == w_rd))));

   assign w_in_ready = (!r_valid || bus.out_ready) && !w_hz && !bus.flush;
   assign w_xfer     = bus.in_valid && w_in_ready;
   assign w_issue    = r_valid && bus.out_ready;

   // One-entry output register toward execute; flush discards the entry
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_op       <= OP_LUI;
         r_funct3   <= 3'd0;
         r_funct7b5 <= 1'b0;
         r_rd       <= 4'd0;
         r_rs1_val  <= '0;
         r_rs2_val  <= '0;
         r_imm      <= '0;
         r_illegal  <= 1'b0;
      end else if (bus.flush) begin
         r_valid    <= 1'b0;
      end else if (w_xfer) begin
         r_valid    <= 1'b1;
         r_pc       <= bus.in_pc;
         r_op       <= w_op;
         r_funct3   <= w_inst[14:12];
         r_funct7b5 <= w_inst[30];
         r_rd       <= w_rd;
         r_rs1_val  <= (w_rs1 == 4'd0) ? '0 : bus.rf_rs1_data;
         r_rs2_val  <= (w_rs2 == 4'd0) ? '0 : bus.rf_rs2_data;
         r_imm      <= w_imm;
         r_illegal  <= w_illegal;
      end else if (bus.out_ready) begin
         r_valid    <= 1'b0;
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = r_valid;
   assign bus.out_pc       = r_pc;
   assign bus.out_op       = r_op;
   assign bus.out_funct3   = r_funct3;
   assign bus.out_funct7b5 = r_funct7b5;
   assign bus.out_rd       = r_rd;
   assign bus.out_rs1_val  = r_rs1_val;
   assign bus.out_rs2_val  = r_rs2_val;
   assign bus.out_imm      = r_imm;
   assign bus.out_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_decode_stage
// Directed vectors for decode_stage with a queue-based scoreboard: the driver
// pushes hand-computed expected entries, the monitor pops them as execute
// accepts each entry.
// Revision: 1.0 - initial release
// ============================================================================
module tb_decode_stage;
   import rv32e_pkg::*;

   typedef struct {
      logic [31:0] pc;
      op_class_t   op;
      logic [2:0]  f3;
      logic        f7;
      logic [3:0]  rd;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];

   decode_stage_if #(.XLEN(32), .RW(4)) bus ();

   decode_stage #(.XLEN(32), .NREGS(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Register-file model: each register reads as 0x1000_000r
   assign bus.rf_rs1_data = 32'h1000_0000 | {28'd0, bus.rf_rs1_addr};
   assign bus.rf_rs2_data = 32'h1000_0000 | {28'd0, bus.rf_rs2_addr};

   function automatic exp_t mk(input logic [31:0] pc, input op_class_t op,
                               input logic [2:0] f3, input logic f7, input logic [3:0] rd,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic ill);
      exp_t e;
      e.pc = pc; e.op = op; e.f3 = f3; e.f7 = f7; e.rd = rd;
      e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.ill = ill;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Presents one word and waits (bounded) for acceptance
   task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus.in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      n_tests++;
      if (ok) q.push_back(e);
      else begin
         n_fail++;
         $display("FAIL accept_timeout: inst %h never accepted, expected acceptance", inst);
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Monitor: compares every entry execute accepts against the queue head
   always @(negedge clock) begin
      if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.flush === 1'b0) begin
         exp_t e;
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_entry: got pc=%h with no entry expected", bus.out_pc);
         end else begin
            e = q.pop_front();
            if (bus.out_pc !== e.pc || bus.out_op !== e.op || bus.out_funct3 !== e.f3 ||
                bus.out_funct7b5 !== e.f7 || bus.out_rd !== e.rd || bus.out_rs1_val !== e.rs1 ||
                bus.out_rs2_val !== e.rs2 || bus.out_imm !== e.imm || bus.out_illegal !== e.ill) begin
               n_fail++;
               $display("FAIL entry: got pc=%h op=%0d f3=%0d f7=%b rd=%0d rs1=%h rs2=%h imm=%h ill=%b, expected pc=%h op=%0d f3=%0d f7=%b rd=%0d rs1=%h rs2=%h imm=%h ill=%b",
                        bus.out_pc, bus.out_op, bus.out_funct3, bus.out_funct7b5, bus.out_rd,
                        bus.out_rs1_val, bus.out_rs2_val, bus.out_imm, bus.out_illegal,
                        e.pc, e.op, e.f3, e.f7, e.rd, e.rs1, e.rs2, e.imm, e.ill);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_inst   = 32'd0;
      bus.in_pc     = 32'd0;
      bus.out_ready = 1'b1;
      bus.wb_valid  = 1'b0;
      bus.wb_rd     = 4'd0;
      bus.flush     = 1'b0;
      repeat (3) tick();
      reset = 1'b1;

      // Reset state
      @(negedge clock);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_pc", bus.out_pc, 32'd0);
      check("rst_out_imm", bus.out_imm, 32'd0);
      check("rst_out_rd", 32'(bus.out_rd), 32'd0);
      check("rst_busy", 32'(dut.u_scoreboard.busy), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      tick();

      // addi x1,x0,5
      send(32'h0050_0093, 32'h0, mk(32'h0, OP_ALU_IMM, 3'd0, 1'b0, 4'd1, 32'h0, 32'h1000_0005, 32'd5, 1'b0));

      // add x2,x1,x1 stalls on x1 until the cycle after its writeback
      bus.in_valid = 1'b1; bus.in_inst = 32'h0010_8133; bus.in_pc = 32'h4;
      @(negedge clock);
      check("raw_stall_held_entry", 32'(bus.in_ready), 32'd0);
      tick();
      @(negedge clock);
      check("raw_stall_busy", 32'(bus.in_ready), 32'd0);
      check("busy_x1_set", 32'(dut.u_scoreboard.busy), 32'h0002);
      tick();
      bus.wb_valid = 1'b1; bus.wb_rd = 4'd1;
      @(negedge clock);
      check("raw_stall_wb_cycle", 32'(bus.in_ready), 32'd0);
      tick();
      bus.wb_valid = 1'b0;
      send(32'h0010_8133, 32'h4, mk(32'h4, OP_ALU, 3'd0, 1'b0, 4'd2, 32'h1000_0001, 32'h1000_0001, 32'd0, 1'b0));

      // Back-to-back hazard-free words
      send(32'hFE00_0EE3, 32'h100, mk(32'h100, OP_BRANCH, 3'd0, 1'b1, 4'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0));
      send(32'h0010_2423, 32'h104, mk(32'h104, OP_STORE, 3'd2, 1'b0, 4'd0, 32'h0, 32'h1000_0001, 32'd8, 1'b0));
      send(32'h0050_0813, 32'h108, mk(32'h108, OP_ILLEGAL, 3'd0, 1'b0, 4'd0, 32'h0, 32'h1000_0005, 32'd0, 1'b1));
      send(32'h0000_0000, 32'h10C, mk(32'h10C, OP_ILLEGAL, 3'd0, 1'b0, 4'd0, 32'h0, 32'h0, 32'd0, 1'b1));
      repeat (2) tick();
      @(negedge clock);
      check("busy_only_x2", 32'(dut.u_scoreboard.busy), 32'h0004);
      tick();
      bus.wb_valid = 1'b1; bus.wb_rd = 4'd2;
      tick();
      bus.wb_valid = 1'b0;
      @(negedge clock);
      check("busy_x2_cleared", 32'(dut.u_scoreboard.busy), 32'h0000);
      tick();

      // lui x3 held for three cycles, then flushed while execute is ready
      bus.out_ready = 1'b0;
      send(32'h1234_51B7, 32'h110, mk(32'h110, OP_LUI, 3'd5, 1'b0, 4'd3, 32'h1000_0008, 32'h1000_0003, 32'h1234_5000, 1'b0));
      e = q[$];
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_imm", bus.out_imm, e.imm);
         check("hold_rd", 32'(bus.out_rd), 32'(e.rd));
         check("hold_rs1", bus.out_rs1_val, e.rs1);
         tick();
      end
      bus.flush = 1'b1; bus.out_ready = 1'b1;
      @(negedge clock);
      check("flush_blocks_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      bus.flush = 1'b0;
      void'(q.pop_back());
      @(negedge clock);
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_busy_x3", 32'(dut.u_scoreboard.busy), 32'h0000);
      tick();

      // Same-cycle issue and writeback of x5: set wins
      send(32'h0010_0293, 32'h114, mk(32'h114, OP_ALU_IMM, 3'd0, 1'b0, 4'd5, 32'h0, 32'h1000_0001, 32'd1, 1'b0));
      bus.wb_valid = 1'b1; bus.wb_rd = 4'd5;
      tick();
      bus.wb_valid = 1'b0;
      @(negedge clock);
      check("issue_wb_same_reg", 32'(dut.u_scoreboard.busy), 32'h0020);
      tick();

      // Reset while an entry is held
      bus.out_ready = 1'b0;
      send(32'hFE00_0EE3, 32'h200, mk(32'h200, OP_BRANCH, 3'd0, 1'b1, 4'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0));
      void'(q.pop_back());
      reset = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clock);
      check("midhold_rst_valid", 32'(bus.out_valid), 32'd0);
      check("midhold_rst_pc", bus.out_pc, 32'd0);
      check("midhold_rst_imm", bus.out_imm, 32'd0);
      check("midhold_rst_busy", 32'(dut.u_scoreboard.busy), 32'd0);
      bus.out_ready = 1'b1;
      repeat (3) tick();

      check("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
